// File: rtl/fib_run_controller_if.sv
// Control and generator-side signals of the Fibonacci run controller.
// master drives requests and the generator value; slave is the controller.
interface fib_run_controller_if #(
    parameter int WIDTH  = 10,
    parameter int TERM_W = 5
);
    logic              start;
    logic [TERM_W-1:0] term;
    logic              abort;
    logic [WIDTH-1:0]  fib_value;
    logic              fib_clear;
    logic              fib_step;
    logic              busy;
    logic              done;
    logic [WIDTH-1:0]  result;
    logic              overflow;

    modport master (
        output start, term, abort, fib_value,
        input  fib_clear, fib_step, busy, done, result, overflow
    );

    modport slave (
        input  start, term, abort, fib_value,
        output fib_clear, fib_step, busy, done, result, overflow
    );
endinterface

// File: rtl/fib_run_controller.sv
// Clears an external Fibonacci generator, issues N paced step pulses, captures F(N).
// done pulses 2+N+(N-1)*PACE cycles after start (N=0: 2; rejected N: on the accepting edge).
module fib_run_controller #(
    parameter int WIDTH    = 10,
    parameter int TERM_W   = 5,
    parameter int PACE     = 0,
    parameter int MAX_TERM = 16
) (
    input  logic                i_clock,
    input  logic                i_reset,
    fib_run_controller_if.slave bus
);
    localparam int                PACE_W      = (PACE < 1) ? 1 : $clog2(PACE + 1);
    localparam logic [TERM_W-1:0] MAX_T       = TERM_W'(MAX_TERM);
    localparam logic [PACE_W-1:0] PACE_RELOAD = PACE_W'((PACE < 1) ? 0 : PACE - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_STEP,
        S_GAP,
        S_SAMPLE,
        S_DONE
    } state_t;

    state_t            r_state, w_state_nxt;
    logic [TERM_W-1:0] r_step_cnt, w_step_cnt_nxt;
    logic [TERM_W-1:0] r_term_q, w_term_q_nxt;
    logic [TERM_W-1:0] w_step_inc;
    logic [PACE_W-1:0] r_pace_cnt, w_pace_cnt_nxt;
    logic [WIDTH-1:0]  r_result, w_result_nxt;
    logic              r_overflow, w_overflow_nxt;
    logic              w_abortable;

    assign w_step_inc  = r_step_cnt + 1'b1;
    assign w_abortable = (r_state == S_CLEAR) || (r_state == S_STEP) ||
                         (r_state == S_GAP)   || (r_state == S_SAMPLE);

    always_comb begin
        w_state_nxt    = r_state;
        w_step_cnt_nxt = r_step_cnt;
        w_term_q_nxt   = r_term_q;
        w_pace_cnt_nxt = r_pace_cnt;
        w_result_nxt   = r_result;
        w_overflow_nxt = r_overflow;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_term_q_nxt   = bus.term;
                    w_overflow_nxt = 1'b0;
                    // Out-of-range requests skip the generator entirely.
                    if (bus.term > MAX_T) begin
                        w_overflow_nxt = 1'b1;
                        w_state_nxt    = S_DONE;
                    end else begin
                        w_state_nxt    = S_CLEAR;
                    end
                end
            end
            S_CLEAR: begin
                w_step_cnt_nxt = '0;
                w_state_nxt    = (r_term_q == '0) ? S_SAMPLE : S_STEP;
            end
            S_STEP: begin
                w_step_cnt_nxt = w_step_inc;
                if (w_step_inc == r_term_q) begin
                    w_state_nxt = S_SAMPLE;
                end else if (PACE == 0) begin
                    w_state_nxt = S_STEP;
                end else begin
                    w_pace_cnt_nxt = PACE_RELOAD;
                    w_state_nxt    = S_GAP;
                end
            end
            S_GAP: begin
                if (r_pace_cnt == '0) begin
                    w_state_nxt = S_STEP;
                end else begin
                    w_pace_cnt_nxt = r_pace_cnt - 1'b1;
                end
            end
            S_SAMPLE: begin
                w_result_nxt = bus.fib_value;
                w_state_nxt  = S_DONE;
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
        // Abort wins over every in-run transition, including the capture.
        if (w_abortable && bus.abort) begin
            w_state_nxt  = S_IDLE;
            w_result_nxt = r_result;
        end
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_state    <= S_IDLE;
            r_step_cnt <= '0;
            r_term_q   <= '0;
            r_pace_cnt <= '0;
            r_result   <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_step_cnt <= w_step_cnt_nxt;
            r_term_q   <= w_term_q_nxt;
            r_pace_cnt <= w_pace_cnt_nxt;
            r_result   <= w_result_nxt;
            r_overflow <= w_overflow_nxt;
        end
    end

    assign bus.fib_clear = (r_state == S_CLEAR);
    assign bus.fib_step  = (r_state == S_STEP);
    assign bus.busy      = (r_state != S_IDLE);
    assign bus.done      = (r_state == S_DONE);
    assign bus.result    = r_result;
    assign bus.overflow  = r_overflow;
endmodule

// File: doc/fib_run_controller.md
Name: fib_run_controller

Overview:
- Sequences an external Fibonacci step generator: clears it, issues exactly N step enables with optional pacing, captures the settled value, and reports completion through a start/busy/done handshake.
- The generator is a register pair (prev, curr):
  - clear loads prev=0, curr=1.
  - step loads prev<=curr, curr<=curr+prev.
  - fib_value is prev, so after k steps fib_value=F(k), where F(0)=0 and F(1)=1.
- The controller sits between control logic (or a switch/button front end) and the generator's clear and count-enable inputs.

Parameters:
- WIDTH, 10, width of fib_value and result.
- TERM_W, 5, width of the term request.
- PACE, 0, idle cycles inserted between consecutive step pulses (0 gives back-to-back steps).
- MAX_TERM, 16, largest term accepted; F(16)=987 fits in 10 bits.

Ports:
- clock  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  request a run; sampled only in IDLE.
- term  in  TERM_W  requested term index N; latched on the edge that accepts start.
- abort  in  1  cancel the run in progress.
- fib_value  in  WIDTH  generator prev output.
- fib_clear  out  1  synchronous clear to the generator.
- fib_step  out  1  count enable to the generator; one step per high cycle.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at the end of a run.
- result  out  WIDTH  captured F(N); holds its value between runs.
- overflow  out  1  last accepted request had N > MAX_TERM.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, step_cnt=0, pace_cnt=0.
  - All outputs 0 immediately, including result and overflow.
  - Reset asserted mid-run abandons the run; no done pulse is produced.
- States: IDLE, CLEAR, STEP, GAP, SAMPLE, DONE.
- Output decode and registers:
  - fib_clear=1 only in CLEAR; fib_step=1 only in STEP.
  - Both are decoded from the registered state, so they carry no combinational path from inputs.
  - step_cnt and term_q are TERM_W bits wide; pace_cnt is sized to hold PACE.
- IDLE:
  - On start=1: latch term_q<=term and clear overflow.
  - If term > MAX_TERM: set overflow=1 and go directly to DONE. No clear or step pulses are issued and result is unchanged.
  - Otherwise go to CLEAR.
- CLEAR: step_cnt<=0. If term_q==0 go to SAMPLE, else go to STEP.
- STEP:
  - step_cnt<=step_cnt+1.
  - If step_cnt+1==term_q, go to SAMPLE.
  - Else if PACE==0, stay in STEP.
  - Else load pace_cnt<=PACE-1 and go to GAP.
- GAP: decrement pace_cnt; when pace_cnt==0, go to STEP.
- SAMPLE:
  - fib_value has settled to F(term_q).
  - result<=fib_value on the exit edge; go to DONE.
- DONE: done=1 for exactly one cycle, then IDLE. busy stays high during DONE.
- Latency:
  - With start accepted at edge E0 and S = step+gap cycles = N+(N-1)*PACE (S=0 for N=0), done is high in the cycle starting at edge E0+2+S.
  - result updates on that same edge.
  - Rejected request: done is high in the cycle starting at E0+1.
- Handshake rules:
  - start while busy=1 is ignored and is not queued.
  - start held high is re-accepted on the first IDLE cycle after DONE.
- abort:
  - abort=1 in CLEAR, STEP, GAP or SAMPLE forces IDLE on the next edge.
  - fib_step/fib_clear drop that edge; result is unchanged; no done pulse.
  - abort is ignored in IDLE and DONE.
  - abort and start both high in IDLE: start is accepted.
- term changes after acceptance have no effect on the run in progress.

Test Plan:
- Bench setup: a behavioural generator model is connected to fib_clear/fib_step/fib_value for all runs.
- Reset: reset=0 mid-run with fib_step high -> all outputs 0 in the same cycle; release, then start with term=5 -> result=5.
- Basic runs, PACE=0:
  - term=0 -> one fib_clear, zero fib_step, done at E0+2, result=0.
  - term=7 -> 7 consecutive fib_step cycles, done at E0+9, result=13.
- Pacing, PACE=2, term=4 -> fib_step pattern 1,0,0,1,0,0,1,0,0,1; done at E0+12; result=3.
- Boundaries:
  - term=16 -> result=987, overflow=0.
  - term=17 -> no fib_clear/fib_step, done at E0+1, overflow=1, result still 987.
  - Next start with term=1 -> overflow=0, result=1.
- Abort and handshake:
  - abort during the 3rd step of term=10 -> IDLE next edge, no done, result unchanged, fib_step low.
  - start pulsed while busy -> ignored; the step count still equals the original term.
